// File: rtl/ureg_pkg.sv
// ureg_pkg -- shared mode encodings for the universal register (rev 1.0)
`default_nettype none

package ureg_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_HOLD = 3'd0,
      OP_SHL  = 3'd1,
      OP_SHR  = 3'd2,
      OP_ROL  = 3'd3,
      OP_ROR  = 3'd4,
      OP_INC  = 3'd5,
      OP_DEC  = 3'd6,
      OP_ASR  = 3'd7
   } op_t;

endpackage

`default_nettype wire

// File: rtl/ureg_if.sv
// ureg_if -- control/data bundle between a datapath master and ureg (rev 1.0)
`default_nettype none

interface ureg_if
   import ureg_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             set;
   logic             ld;
   op_t              op;
   logic [WIDTH-1:0] din;
   logic             cin;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] dout;
   logic             cout;
   logic             zero;
   logic             full;
   logic             empty;
   logic             err;

   modport master (
      output clr, set, ld, op, din, cin, push, pop,
      input  dout, cout, zero, full, empty, err
   );

   modport slave (
      input  clr, set, ld, op, din, cin, push, pop,
      output dout, cout, zero, full, empty, err
   );
endinterface

`default_nettype wire

// File: rtl/ureg_lifo.sv
// ureg_lifo -- DEPTH-entry save/restore stack with exchange support (rev 1.0)
`default_nettype none

module ureg_lifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic             err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             at_full;
   logic             at_empty;
   logic             xchg;
   logic             do_push;
   logic             do_pop;

   assign at_full  = (count == CW'(DEPTH));
   assign at_empty = (count == '0);
   assign top_idx  = AW'(count) - AW'(1);
   assign wr_idx   = AW'(count);
   assign rdata    = mem[top_idx];

   // Exchange wins over plain push/pop whenever there is a top entry, even when full.
   assign xchg     = push && pop && !at_empty;
   assign do_push  = push && !xchg && !at_full;
   assign do_pop   = pop && !push && !at_empty;

   always_comb begin
      count_nxt = count;
      if (do_push) begin
         count_nxt = count + CW'(1);
      end else if (do_pop) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         err   <= 1'b0;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
         err   <= (push && !pop && at_full) || (pop && at_empty);
      end
   end

   // Storage is deliberately left uninitialised by reset; only the count matters.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (do_push) begin
            mem[wr_idx] <= wdata;
         end else if (xchg) begin
            mem[top_idx] <= wdata;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ureg.sv
// ureg -- universal register: priority mux, shift/rotate/count datapath, carry-out (rev 1.0)
`default_nettype none

module ureg
   import ureg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic  clk,
   input  logic  rst,
   ureg_if.slave bus
);
   logic [WIDTH-1:0] value;
   logic             carry;
   logic [WIDTH-1:0] op_val;
   logic             op_carry;
   logic [WIDTH-1:0] top;
   logic             pop_ok;

   ureg_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.push),
      .pop   (bus.pop),
      .wdata (value),
      .rdata (top),
      .full  (bus.full),
      .empty (bus.empty),
      .err   (bus.err)
   );

   assign pop_ok = bus.pop && !bus.empty;

   always_comb begin
      op_val   = value;
      op_carry = carry;
      case (bus.op)
         OP_SHL: begin
            op_val   = {value[WIDTH-2:0], bus.cin};
            op_carry = value[WIDTH-1];
         end
         OP_SHR: begin
            op_val   = {bus.cin, value[WIDTH-1:1]};
            op_carry = value[0];
         end
         OP_ROL: begin
            op_val   = {value[WIDTH-2:0], value[WIDTH-1]};
            op_carry = value[WIDTH-1];
         end
         OP_ROR: begin
            op_val   = {value[0], value[WIDTH-1:1]};
            op_carry = value[0];
         end
         // Extra MSB of the widened sum is the carry (INC) or borrow (DEC).
         OP_INC:  {op_carry, op_val} = {1'b0, value} + (WIDTH+1)'(1);
         OP_DEC:  {op_carry, op_val} = {1'b0, value} - (WIDTH+1)'(1);
         OP_ASR: begin
            op_val   = {value[WIDTH-1], value[WIDTH-1:1]};
            op_carry = value[0];
         end
         default: begin
            op_val   = value;
            op_carry = carry;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= RST_VAL;
         carry <= 1'b0;
      end else if (bus.clr) begin
         value <= '0;
         carry <= 1'b0;
      end else if (bus.set) begin
         value <= '1;
         carry <= 1'b0;
      end else if (pop_ok) begin
         value <= top;
      end else if (bus.ld) begin
         value <= bus.din;
      end else begin
         value <= op_val;
         carry <= op_carry;
      end
   end

   assign bus.dout = value;
   assign bus.cout = carry;
   assign bus.zero = (value == '0);

endmodule

`default_nettype wire

// File: tb/tb_ureg.sv
// tb_ureg -- directed self-checking bench for ureg (WIDTH=8, DEPTH=4, RST_VAL=A5) (rev 1.0)
`default_nettype none

module tb_ureg;
   import ureg_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   ureg_if #(.WIDTH(8)) bus ();

   ureg #(
      .WIDTH   (8),
      .DEPTH   (4),
      .RST_VAL (8'hA5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.clr  = 1'b0;
      bus.set  = 1'b0;
      bus.ld   = 1'b0;
      bus.op   = OP_HOLD;
      bus.din  = 8'h00;
      bus.cin  = 1'b0;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   task automatic load(input logic [7:0] v);
      idle();
      bus.ld  = 1'b1;
      bus.din = v;
      step();
   endtask

   task automatic do_op(input op_t o, input logic c);
      idle();
      bus.op  = o;
      bus.cin = c;
      step();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      chk("rst_dout", bus.dout, 8'hA5);
      chk("rst_cout", bus.cout, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_zero", bus.zero, 0);
      rst = 1'b0;

      // Priority: clr over set over ld
      bus.clr = 1'b1; bus.set = 1'b1; bus.ld = 1'b1; bus.din = 8'd13;
      step();
      chk("prio_clr", bus.dout, 8'h00);
      chk("prio_clr_zero", bus.zero, 1);
      bus.clr = 1'b0;
      step();
      chk("prio_set", bus.dout, 8'hFF);
      bus.set = 1'b0;
      step();
      chk("ld", bus.dout, 8'h0D);
      chk("ld_cout", bus.cout, 0);

      // Shift/rotate/count modes
      load(8'h81);
      do_op(OP_SHL, 1'b0);
      chk("shl", bus.dout, 8'h02);
      chk("shl_cout", bus.cout, 1);
      do_op(OP_SHR, 1'b0);
      chk("shr", bus.dout, 8'h01);
      chk("shr_cout", bus.cout, 0);
      do_op(OP_HOLD, 1'b1);
      chk("hold", bus.dout, 8'h01);
      chk("hold_cout", bus.cout, 0);
      load(8'h81);
      do_op(OP_ROR, 1'b0);
      chk("ror", bus.dout, 8'hC0);
      chk("ror_cout", bus.cout, 1);
      load(8'h81);
      chk("ld_keeps_cout", bus.cout, 1);
      do_op(OP_ROL, 1'b0);
      chk("rol", bus.dout, 8'h03);
      chk("rol_cout", bus.cout, 1);
      idle(); bus.clr = 1'b1; step();
      chk("clr_cout", bus.cout, 0);
      load(8'h81);
      do_op(OP_ASR, 1'b0);
      chk("asr", bus.dout, 8'hC0);
      chk("asr_cout", bus.cout, 1);
      do_op(OP_SHR, 1'b1);
      chk("shr_cin", bus.dout, 8'hE0);
      chk("shr_cin_cout", bus.cout, 0);
      load(8'hFF);
      do_op(OP_INC, 1'b0);
      chk("inc", bus.dout, 8'h00);
      chk("inc_cout", bus.cout, 1);
      chk("inc_zero", bus.zero, 1);
      do_op(OP_DEC, 1'b0);
      chk("dec", bus.dout, 8'hFF);
      chk("dec_cout", bus.cout, 1);
      do_op(OP_DEC, 1'b0);
      chk("dec2", bus.dout, 8'hFE);
      chk("dec2_cout", bus.cout, 0);

      // Stack fill: each push stores the pre-edge dout while ld brings the next value
      load(8'd1);
      for (int i = 2; i <= 5; i++) begin
         idle(); bus.push = 1'b1; bus.ld = 1'b1; bus.din = 8'(i);
         step();
      end
      chk("fill_full", bus.full, 1);
      chk("fill_empty", bus.empty, 0);
      chk("fill_err", bus.err, 0);
      chk("fill_dout", bus.dout, 8'd5);
      idle(); bus.push = 1'b1; step();
      chk("over_err", bus.err, 1);
      chk("over_full", bus.full, 1);
      idle(); step();
      chk("over_err_clear", bus.err, 0);

      for (int i = 4; i >= 1; i--) begin
         idle(); bus.pop = 1'b1; step();
         chk("drain_dout", bus.dout, 32'(i));
         chk("drain_full", bus.full, 0);
         chk("drain_empty", bus.empty, (i == 1) ? 1 : 0);
      end
      idle(); bus.pop = 1'b1; step();
      chk("under_err", bus.err, 1);
      chk("under_dout", bus.dout, 8'd1);
      idle(); step();
      chk("under_err_clear", bus.err, 0);

      // Exchange
      load(8'd3);
      idle(); bus.push = 1'b1; bus.ld = 1'b1; bus.din = 8'd7; step();
      chk("xchg_pre", bus.dout, 8'd7);
      idle(); bus.push = 1'b1; bus.pop = 1'b1; step();
      chk("xchg_dout", bus.dout, 8'd3);
      chk("xchg_err", bus.err, 0);
      chk("xchg_empty", bus.empty, 0);
      idle(); bus.pop = 1'b1; step();
      chk("xchg_top", bus.dout, 8'd7);
      chk("xchg_drained", bus.empty, 1);

      // Push+pop on empty: push happens, pop flagged
      load(8'h5A);
      idle(); bus.push = 1'b1; bus.pop = 1'b1; step();
      chk("pp_empty_err", bus.err, 1);
      chk("pp_empty_dout", bus.dout, 8'h5A);
      chk("pp_empty_empty", bus.empty, 0);
      load(8'h00);
      idle(); bus.pop = 1'b1; step();
      chk("pp_empty_pop", bus.dout, 8'h5A);

      // Pop losing to clr is still consumed
      load(8'h11);
      idle(); bus.push = 1'b1; step();
      idle(); bus.pop = 1'b1; bus.clr = 1'b1; step();
      chk("pop_clr_dout", bus.dout, 8'h00);
      chk("pop_clr_empty", bus.empty, 1);

      // Reset in the middle of a push
      load(8'h21);
      idle(); bus.push = 1'b1; step();
      idle(); bus.push = 1'b1; step();
      idle(); bus.push = 1'b1; rst = 1'b1; step();
      rst = 1'b0;
      chk("mrst_dout", bus.dout, 8'hA5);
      chk("mrst_empty", bus.empty, 1);
      chk("mrst_full", bus.full, 0);
      idle(); bus.pop = 1'b1; step();
      chk("mrst_pop_err", bus.err, 1);
      chk("mrst_pop_dout", bus.dout, 8'hA5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
